// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: the fetch FSM state
// encoding, the queue entry layout and the instruction word size.
package fetch_pkg;

   localparam int          INST_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Fetch addresses are always word aligned; low bits of a target are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of the fetch unit's redirect, instruction-memory and decode-side
// signals. The master modport is the fetch unit; slave is its environment.
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high at the rising clock edge. valid must not depend on ready. The memory
// response channel has no ready: imem_rsp_valid is always accepted.
interface pc_fetch_unit_if;
   import fetch_pkg::*;

   logic         redirect_en;
   logic [31:0]  redirect_pc;
   logic         imem_req_valid;
   logic         imem_req_ready;
   logic [31:0]  imem_req_addr;
   logic         imem_rsp_valid;
   logic [31:0]  imem_rsp_data;
   logic         inst_valid;
   logic         inst_ready;
   logic [31:0]  inst_data;
   logic [31:0]  inst_pc;
   logic         flush;
   logic         misaligned;
   fetch_state_e dbg_state;

   modport master (
      input  redirect_en, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
             flush, misaligned, dbg_state
   );

   modport slave (
      output redirect_en, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
             flush, misaligned, dbg_state
   );

endinterface

// File: rtl/pc_fetch_unit_queue.sv
// fetch_queue: small synchronous FIFO of fetched {pc, inst} entries toward
// decode. clear_i empties it in one cycle and overrides push/pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   output fetch_entry_t             pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign empty_o    = (count_q == '0);

   // The issue credit rule must make overflow impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !pop_i && !clear_i && count_q == (PW+1)'(DEPTH)));

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop_i && !clear_i && count_q == '0));

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the fetch PC, issues in-order instruction-memory
// requests, queues responses toward decode and restarts on redirect,
// dropping stale responses that are still in flight.
// Optional feature macro: MISALIGN_TRAP_EN (a misaligned redirect target
// sets a sticky flag and halts fetch instead of being silently aligned).
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          FQ_DEPTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   pc_fetch_unit_if.master bus
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] q_count;
   logic          q_empty, q_push, q_pop;
   fetch_entry_t  q_head, q_wdata;
   logic          redirect_take, mis_redirect, credit_ok;
   logic          req_valid, req_fire, rsp_drop;

   // Request issue, response acceptance and redirect qualification.
   always_comb begin
      redirect_take = bus.redirect_en && (state_q != HALT);
`ifdef MISALIGN_TRAP_EN
      mis_redirect  = redirect_take && (bus.redirect_pc[1:0] != 2'b00);
`else
      mis_redirect  = 1'b0;
`endif
      // Queued plus outstanding never exceeds the queue depth, so every
      // response has a slot waiting for it.
      credit_ok = ({1'b0, q_count} + {1'b0, inflight_q}) < (CW+1)'(FQ_DEPTH);
      req_valid = (state_q == RUN) && !bus.redirect_en && credit_ok;
      req_fire  = req_valid && bus.imem_req_ready;
      rsp_drop  = (drop_cnt_q != '0);
      q_push    = bus.imem_rsp_valid && !bus.redirect_en && !rsp_drop &&
                  (state_q != HALT);
      q_pop     = !q_empty && bus.inst_ready;
      q_wdata.pc   = rsp_pc_q;
      q_wdata.inst = bus.imem_rsp_data;
   end

   // Next state: FSM, fetch PC, response PC and in-flight bookkeeping.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_cnt_d = drop_cnt_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);

      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         HALT:    state_d = HALT;
         default: state_d = BOOT;
      endcase
      if (mis_redirect) state_d = HALT;

      if (redirect_take) begin
         // Everything still outstanding belongs to the old stream; the one
         // response arriving now is already discarded.
         drop_cnt_d = inflight_q - CW'(bus.imem_rsp_valid);
         pc_d       = align_pc(bus.redirect_pc);
         rsp_pc_d   = align_pc(bus.redirect_pc);
      end else begin
         if (bus.imem_rsp_valid && rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
         if (req_fire) pc_d     = pc_q + 32'(INST_BYTES);
         if (q_push)   rsp_pc_d = rsp_pc_q + 32'(INST_BYTES);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (bus.redirect_en),
      .push_i      (q_push),
      .push_data_i (q_wdata),
      .pop_i       (q_pop),
      .pop_data_o  (q_head),
      .count_o     (q_count),
      .empty_o     (q_empty)
   );

`ifdef MISALIGN_TRAP_EN
   logic misaligned_q;

   // Sticky misaligned-target flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            misaligned_q <= 1'b0;
      else if (mis_redirect) misaligned_q <= 1'b1;
   end

   assign bus.misaligned = misaligned_q;
`else
   assign bus.misaligned = 1'b0;
`endif

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = !q_empty;
   assign bus.inst_data      = q_head.inst;
   assign bus.inst_pc        = q_head.pc;
   assign bus.flush          = bus.redirect_en;
   assign bus.dbg_state      = state_q;

   // Memory must never return more responses than were requested.
   a_no_rsp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.imem_rsp_valid && inflight_q == '0));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: randomized memory timing, decode
// backpressure and redirects, checked every cycle against an epoch-based
// reference model of the fetch stream.
module tb_pc_fetch_unit;
   import fetch_pkg::*;

   localparam int FQ_DEPTH = 2;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } pend_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pc_fetch_unit_if bus ();

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(FQ_DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];      // {pc, inst} expected at decode, in order
   pend_t       pend_q[$];     // requests issued and not yet answered
   logic [31:0] exp_req_pc;
   int          epoch = 0;
   int          cyc = 0;
   int          last_due = 0;
   bit          booted = 0;
   bit          halted = 0;
   bit          exp_mis = 0;
   int          deq_dut = 0;

   // ---------------- stimulus knobs ----------------
   int          rdy_pct = 100;
   int          irdy_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   int          redir_permil = 0;
   bit          force_redir = 0;
   logic [31:0] force_pc = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // ---------------- driver: one clock cycle ----------------
   // Entered at a falling edge; drives, checks, then updates the model
   // with what happened at the rising edge.
   task automatic step();
      bit           exp_rv, fire, rsp, deq, redir;
      logic [31:0]  tgt, rnd;
      fetch_state_e exp_state;
      pend_t        pe;
      int           due;

      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      bus.inst_ready     = ($urandom_range(99) < irdy_pct);
      redir = 1'b0;
      rnd   = $urandom;
      tgt   = rnd;
      if (force_redir) begin
         redir       = 1'b1;
         tgt         = force_pc;
         force_redir = 1'b0;
      end else if ($urandom_range(999) < redir_permil) begin
         redir = 1'b1;
         tgt   = {rnd[31:2], 2'b00};
      end
      bus.redirect_en    = redir;
      bus.redirect_pc    = tgt;
      rsp                = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_fn(pend_q[0].addr) : $urandom;
      #1;

      exp_rv = booted && !halted && !redir &&
               ((exp_q.size() + pend_q.size()) < FQ_DEPTH);
      exp_state = !booted ? BOOT : (halted ? HALT : RUN);
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", bus.imem_req_addr, exp_req_pc);
      check("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("inst_pc", bus.inst_pc, exp_q[0][63:32]);
         check("inst_data", bus.inst_data, exp_q[0][31:0]);
      end
      check("flush", 32'(bus.flush), 32'(redir));
      check("misaligned", 32'(bus.misaligned), 32'(exp_mis));
      check("state", 32'(bus.dbg_state), 32'(exp_state));

      fire = exp_rv && bus.imem_req_ready;
      deq  = (exp_q.size() != 0) && bus.inst_ready;
      if (bus.inst_valid && bus.inst_ready && !redir) deq_dut++;

      @(posedge clk);
      if (deq) void'(exp_q.pop_front());
      if (rsp) begin
         pe = pend_q.pop_front();
         if (!redir && !halted && pe.epoch == epoch)
            exp_q.push_back({pe.addr, mem_fn(pe.addr)});
      end
      if (fire) begin
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_q.push_back('{addr: exp_req_pc, epoch: epoch, due: due});
         exp_req_pc += 32'd4;
      end
      if (redir && !halted) begin
         exp_q.delete();
         epoch++;
         exp_req_pc = tgt & ~32'h3;
`ifdef MISALIGN_TRAP_EN
         if (tgt[1:0] != 2'b00) begin
            halted  = 1'b1;
            exp_mis = 1'b1;
         end
`endif
      end
      booted = 1'b1;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      force_redir = 1'b1;
      force_pc    = pc;
      step();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bus.redirect_en    = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.inst_ready     = 1'b0;
      exp_req_pc         = 32'h0000_0000;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_misaligned", 32'(bus.misaligned), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(BOOT));
      rst_n = 1'b1;

      // Streaming from reset: always-ready memory, 1-cycle latency.
      rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1;
      deq_dut = 0;
      run(60);
      check("stream_throughput", 32'(deq_dut >= 30), 32'd1);

      // Decode stalled: credit cap holds requests back.
      irdy_pct = 0; lat_max = 3;
      run(20);

      // Two outstanding at 3-cycle latency, then redirect to 0x100.
      irdy_pct = 100; lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && pend_q.size() < 2; i++) step();
      redirect_to(32'h0000_0100);
      run(20);

      // Back-to-back redirects with a response landing in the first.
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 20 && !(pend_q.size() > 0 && pend_q[0].due <= cyc); i++) step();
      redirect_to(32'h0000_0200);
      redirect_to(32'h0000_0300);
      run(20);

      // Address wrap at the top of memory.
      lat_min = 1; lat_max = 2;
      redirect_to(32'hFFFF_FFF8);
      run(20);

      // Randomized timing, backpressure and redirects.
      for (int c = 0; c < 30; c++) begin
         rdy_pct      = $urandom_range(100, 30);
         irdy_pct     = $urandom_range(100, 20);
         lat_min      = $urandom_range(3, 1);
         lat_max      = lat_min + $urandom_range(4, 0);
         redir_permil = $urandom_range(60, 0);
         run(100);
      end
      redir_permil = 0;

      // Misaligned redirect target last: halts when the trap is built in.
      rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 3;
      redirect_to(32'h0000_0102);
      run(30);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
